uart_word_tx: RTL

//  Upstream feeder for the byte-wide UART transmitter. Accepts WORD_WIDTH-bit words
//  (e.g. 64-bit PUF responses) over a valid/ready handshake and buffers them in a

---
 rtl/uart_word_tx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx: buffers WORD_WIDTH-bit words in a small FIFO and feeds them byte by
// byte (or as ASCII hex characters) into a byte-wide UART transmitter through the
// ld_tx_data / tx_data / tx_empty handshake.
// Optional feature macro: UART_WORD_TX_HEX_ASCII_EN
//   undefined : raw binary bytes, WORD_WIDTH/8 characters per word, no terminator
//   defined   : two uppercase hex characters per byte (high nibble first), then CR LF
module uart_word_tx #(
  parameter int WORD_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WORD_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [7:0]                    tx_data,
  output logic                          ld_tx_data,
  input  logic                          tx_empty,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int NBYTES = WORD_WIDTH / 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  // Counter is always wide enough for the hex-mode character count.
  localparam int CNT_W  = $clog2(2 * NBYTES + 2);
`ifdef UART_WORD_TX_HEX_ASCII_EN
  localparam int LAST_INT = 2 * NBYTES + 1;
`else
  localparam int LAST_INT = NBYTES - 1;
`endif
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(LAST_INT);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE} state_t;

  logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [WORD_WIDTH-1:0] word_reg;
  logic [CNT_W-1:0]      char_cnt;
  state_t                state;
  logic                  push;
  logic                  pop;

  assign in_ready   = (fifo_level != FULL_LVL);
  assign push       = in_valid & in_ready;
  assign pop        = (state == IDLE) & (fifo_level != '0);
  assign ld_tx_data = (state == LOAD) & tx_empty;
  assign busy       = (state != IDLE) | (fifo_level != '0);

  // Byte number idx of a word, counted in transmission order.
  function automatic logic [7:0] byte_at(input logic [WORD_WIDTH-1:0] w,
                                         input logic [CNT_W-1:0] idx);
    logic [WORD_WIDTH-1:0] sh;
    int i;
    i = int'(idx);
    if (MSB_FIRST)
      sh = w >> (8 * (NBYTES - 1 - i));
    else
      sh = w >> (8 * i);
    return sh[7:0];
  endfunction

`ifdef UART_WORD_TX_HEX_ASCII_EN
  // Uppercase ASCII digit for one nibble.
  function automatic logic [7:0] hex_digit(input logic [3:0] n);
    if (n < 4'd10)
      return {4'h3, n};
    else
      return 8'h37 + {4'h0, n};
  endfunction
`endif

  // Character number c of the stream produced for word w.
  function automatic logic [7:0] char_at(input logic [WORD_WIDTH-1:0] w,
                                         input logic [CNT_W-1:0] c);
`ifdef UART_WORD_TX_HEX_ASCII_EN
    logic [7:0] b;
    if (c == CNT_W'(2 * NBYTES))
      return 8'h0D;
    else if (c == LAST)
      return 8'h0A;
    b = byte_at(w, c >> 1);
    return c[0] ? hex_digit(b[3:0]) : hex_digit(b[7:4]);
`else
    return byte_at(w, c);
`endif
  endfunction

  // FIFO pointers and occupancy; pointers wrap naturally because depth is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Serialiser FSM: pops a word, then loads one character per UART handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_reg <= '0;
      char_cnt <= '0;
      tx_data  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_level != '0) begin
            word_reg <= mem[rd_ptr];
            char_cnt <= '0;
            tx_data  <= char_at(mem[rd_ptr], '0);
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (tx_empty) state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!tx_empty) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_empty) begin
            if (char_cnt == LAST) begin
              state <= IDLE;
            end else begin
              char_cnt <= char_cnt + CNT_W'(1);
              tx_data  <= char_at(word_reg, char_cnt + CNT_W'(1));
              state    <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
